// File: rtl/cmsdk_ahb_error_canc_ext.sv
// AHB error canceller: after an AHB2 error, the rest of the burst is answered locally
// with two-cycle ERROR responses instead of being forwarded to AHB2.
module cmsdk_ahb_error_canc_ext #(
    parameter int CNT_WIDTH   = 8,
    parameter int CANC_INCR   = 1,
    parameter int BURST_TRACK = 1
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 HCLKEN,
    input  logic                 HSELS,
    input  logic [1:0]           HTRANSS,
    input  logic [2:0]           HBURSTS,
    input  logic                 HREADYS,
    output logic                 HREADYOUTS,
    output logic                 HRESPS,
    output logic [1:0]           HTRANSM,
    input  logic                 HREADYM,
    input  logic                 HRESPM,
    input  logic                 CNTCLR,
    output logic [CNT_WIDTH-1:0] ERRCNT,
    output logic [CNT_WIDTH-1:0] CANCCNT,
    output logic                 CANCELLING
);

    typedef enum logic {
        CTRL_PASS,
        CTRL_CANCEL
    } ctrl_state_t;

    typedef enum logic [1:0] {
        G_IDLE,
        G_ERR1,
        G_ERR2
    } gen_state_t;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;
    localparam logic [2:0] BURST_INCR   = 3'b001;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    ctrl_state_t          ctrl_q, ctrl_d;
    gen_state_t           gen_q, gen_d;
    logic [3:0]           beat_cnt_q, beat_cnt_d;
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_WIDTH-1:0] canc_cnt_q, canc_cnt_d;

    logic is_idle, is_busy, is_nonseq, is_seq;
    logic beat_accept, burst_incr, cancellable;
    logic gen_ready, gen_resp, burst_done, leave_cancel;
    logic err_hit, canc_hit, cnt_clear;

    assign is_idle     = (HTRANSS == TRANS_IDLE);
    assign is_busy     = (HTRANSS == TRANS_BUSY);
    assign is_nonseq   = (HTRANSS == TRANS_NONSEQ);
    assign is_seq      = (HTRANSS == TRANS_SEQ);
    assign beat_accept = HCLKEN & HSELS & HREADYS & HTRANSS[1];
    assign burst_incr  = (HBURSTS == BURST_INCR);
    assign cancellable = (is_seq | is_busy) & (~burst_incr | (CANC_INCR != 0));

    assign gen_ready = (gen_q != G_ERR1);
    assign gen_resp  = (gen_q != G_IDLE);

    // A fixed-length burst whose last beat has been seen can be released without waiting for IDLE.
    assign burst_done   = (BURST_TRACK != 0) & ~burst_incr & (beat_cnt_q == 4'd0);
    assign leave_cancel = gen_ready & (is_idle | is_nonseq | burst_done);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ctrl_q <= CTRL_PASS;
            gen_q  <= G_IDLE;
        end else begin
            ctrl_q <= ctrl_d;
            gen_q  <= gen_d;
        end
    end

    // The generator is parked in G_IDLE whenever the control FSM is (or becomes) PASS.
    always_comb begin
        ctrl_d = ctrl_q;
        gen_d  = gen_q;
        if (HCLKEN) begin
            case (ctrl_q)
                CTRL_PASS: begin
                    gen_d = G_IDLE;
                    if (HRESPM && cancellable) begin
                        ctrl_d = CTRL_CANCEL;
                        gen_d  = G_ERR2;
                    end
                end
                CTRL_CANCEL: begin
                    if (leave_cancel) begin
                        ctrl_d = CTRL_PASS;
                        gen_d  = G_IDLE;
                    end else begin
                        case (gen_q)
                            G_IDLE: begin
                                if (HRESPM) begin
                                    gen_d = G_ERR2;
                                end else if (is_seq) begin
                                    gen_d = G_ERR1;
                                end
                            end
                            G_ERR1:  gen_d = G_ERR2;
                            G_ERR2:  gen_d = is_seq ? G_ERR1 : G_IDLE;
                            default: gen_d = G_IDLE;
                        endcase
                    end
                end
                default: begin
                    ctrl_d = CTRL_PASS;
                    gen_d  = G_IDLE;
                end
            endcase
        end
    end

    // NONSEQ is always forwarded so a new burst starting as cancel ends is not lost.
    always_comb begin
        CANCELLING = (ctrl_q == CTRL_CANCEL);
        HTRANSM    = HTRANSS;
        HREADYOUTS = HREADYM;
        HRESPS     = HRESPM;
        if (ctrl_q == CTRL_CANCEL) begin
            HTRANSM    = is_nonseq ? TRANS_NONSEQ : TRANS_IDLE;
            HREADYOUTS = gen_ready;
            HRESPS     = gen_resp;
        end
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (beat_accept) begin
            if (is_nonseq) begin
                case (HBURSTS[2:1])
                    2'b00:   beat_cnt_d = 4'd0;
                    2'b01:   beat_cnt_d = 4'd3;
                    2'b10:   beat_cnt_d = 4'd7;
                    default: beat_cnt_d = 4'd15;
                endcase
            end else if (is_seq && (beat_cnt_q != 4'd0)) begin
                beat_cnt_d = beat_cnt_q - 4'd1;
            end
        end
    end

    assign err_hit   = HCLKEN & (ctrl_q == CTRL_PASS) & HRESPM & ~HREADYM;
    assign canc_hit  = HCLKEN & (gen_d == G_ERR1) & (gen_q != G_ERR1);
    assign cnt_clear = HCLKEN & CNTCLR;

    // Clear wins over a same-cycle increment; both counters stick at all-ones.
    always_comb begin
        err_cnt_d  = err_cnt_q;
        canc_cnt_d = canc_cnt_q;
        if (cnt_clear) begin
            err_cnt_d  = '0;
            canc_cnt_d = '0;
        end else begin
            if (err_hit && (err_cnt_q != CNT_MAX)) begin
                err_cnt_d = err_cnt_q + CNT_ONE;
            end
            if (canc_hit && (canc_cnt_q != CNT_MAX)) begin
                canc_cnt_d = canc_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            beat_cnt_q <= 4'd0;
            err_cnt_q  <= '0;
            canc_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            err_cnt_q  <= err_cnt_d;
            canc_cnt_q <= canc_cnt_d;
        end
    end

    assign ERRCNT  = err_cnt_q;
    assign CANCCNT = canc_cnt_q;

endmodule

// File: tb/tb_cmsdk_ahb_error_canc_ext.sv
// Bench for the AHB error canceller: two parameterisations share one stimulus stream and
// are checked every cycle against a behavioural model, plus directed burst scenarios.
module tb_cmsdk_ahb_error_canc_ext;

   logic HCLK = 1'b0;
   logic HRESETn;
   logic HCLKEN, HSELS, HREADYS, HREADYM, HRESPM, CNTCLR;
   logic [1:0] HTRANSS;
   logic [2:0] HBURSTS;

   logic [1:0] transM [2];
   logic readyOut [2];
   logic respOut [2];
   logic cancellingOut [2];
   logic [7:0] errCnt0, cancCnt0;
   logic [3:0] errCnt1, cancCnt1;

   int testsRun = 0;
   int testsFailed = 0;

   // Model state per instance: cancelling flag, error phase the master is being given
   // (0 none, 1 stalled error cycle, 2 final error cycle), beats left in burst, counters.
   int mCancelling [2];
   int mPhase [2];
   int mLeft [2];
   int mErr [2];
   int mCanc [2];
   int pCancIncr [2] = '{1, 0};
   int pBurstTrack [2] = '{1, 0};
   int pCntMax [2] = '{255, 15};

   always #5 HCLK = ~HCLK;

   cmsdk_ahb_error_canc_ext dut0 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HCLKEN(HCLKEN), .HSELS(HSELS),
      .HTRANSS(HTRANSS), .HBURSTS(HBURSTS), .HREADYS(HREADYS),
      .HREADYOUTS(readyOut[0]), .HRESPS(respOut[0]), .HTRANSM(transM[0]),
      .HREADYM(HREADYM), .HRESPM(HRESPM), .CNTCLR(CNTCLR),
      .ERRCNT(errCnt0), .CANCCNT(cancCnt0), .CANCELLING(cancellingOut[0])
   );

   cmsdk_ahb_error_canc_ext #(.CNT_WIDTH(4), .CANC_INCR(0), .BURST_TRACK(0)) dut1 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HCLKEN(HCLKEN), .HSELS(HSELS),
      .HTRANSS(HTRANSS), .HBURSTS(HBURSTS), .HREADYS(HREADYS),
      .HREADYOUTS(readyOut[1]), .HRESPS(respOut[1]), .HTRANSM(transM[1]),
      .HREADYM(HREADYM), .HRESPM(HRESPM), .CNTCLR(CNTCLR),
      .ERRCNT(errCnt1), .CANCCNT(cancCnt1), .CANCELLING(cancellingOut[1])
   );

   // Counts one comparison and reports it when observed and expected differ.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   function automatic int burstBeats(input logic [2:0] burst);
      case (burst)
         3'd0: return 1;
         3'd1: return 0;
         3'd2, 3'd3: return 4;
         3'd4, 3'd5: return 8;
         default: return 16;
      endcase
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 2; i++) begin
         mCancelling[i] = 0;
         mPhase[i] = 0;
         mLeft[i] = 0;
         mErr[i] = 0;
         mCanc[i] = 0;
      end
   endtask

   // Compares every output of both instances against what the model predicts right now.
   task automatic checkAll();
      int expTrans, expRdy, expResp;
      for (int i = 0; i < 2; i++) begin
         if (mCancelling[i] != 0) begin
            expTrans = (HTRANSS == 2'b10) ? 2 : 0;
            expRdy = (mPhase[i] != 1) ? 1 : 0;
            expResp = (mPhase[i] != 0) ? 1 : 0;
         end else begin
            expTrans = int'(HTRANSS);
            expRdy = int'(HREADYM);
            expResp = int'(HRESPM);
         end
         checkOutput($sformatf("dut%0d_htransm", i), 32'(transM[i]), expTrans);
         checkOutput($sformatf("dut%0d_hreadyouts", i), 32'(readyOut[i]), expRdy);
         checkOutput($sformatf("dut%0d_hresps", i), 32'(respOut[i]), expResp);
         checkOutput($sformatf("dut%0d_cancelling", i), 32'(cancellingOut[i]), mCancelling[i]);
         if (i == 0) begin
            checkOutput("dut0_errcnt", 32'(errCnt0), mErr[0]);
            checkOutput("dut0_canccnt", 32'(cancCnt0), mCanc[0]);
         end else begin
            checkOutput("dut1_errcnt", 32'(errCnt1), mErr[1]);
            checkOutput("dut1_canccnt", 32'(cancCnt1), mCanc[1]);
         end
      end
   endtask

   // Advances the model by one clock using the inputs currently on the bus.
   task automatic modelStep();
      bit acc, isSeq, isBusy, isNonseq, isIdle, incr, errInc, cancInc, burstDone;
      int nextPhase;
      if (!HCLKEN) return;
      acc = HSELS && HREADYS && HTRANSS[1];
      isIdle = (HTRANSS == 2'b00);
      isBusy = (HTRANSS == 2'b01);
      isNonseq = (HTRANSS == 2'b10);
      isSeq = (HTRANSS == 2'b11);
      incr = (HBURSTS == 3'd1);
      for (int i = 0; i < 2; i++) begin
         errInc = 0;
         cancInc = 0;
         if (mCancelling[i] == 0) begin
            errInc = HRESPM && !HREADYM;
            if (HRESPM && (isSeq || isBusy) && (!incr || pCancIncr[i] != 0)) begin
               mCancelling[i] = 1;
               mPhase[i] = 2;
            end else begin
               mPhase[i] = 0;
            end
         end else begin
            burstDone = (pBurstTrack[i] != 0) && !incr && (mLeft[i] == 0);
            if ((mPhase[i] != 1) && (isIdle || isNonseq || burstDone)) begin
               mCancelling[i] = 0;
               nextPhase = 0;
            end else if (mPhase[i] == 1) begin
               nextPhase = 2;
            end else if (mPhase[i] == 2) begin
               nextPhase = isSeq ? 1 : 0;
            end else begin
               nextPhase = HRESPM ? 2 : (isSeq ? 1 : 0);
            end
            cancInc = (nextPhase == 1) && (mPhase[i] != 1);
            mPhase[i] = nextPhase;
         end
         if (CNTCLR) begin
            mErr[i] = 0;
            mCanc[i] = 0;
         end else begin
            if (errInc && mErr[i] < pCntMax[i]) mErr[i]++;
            if (cancInc && mCanc[i] < pCntMax[i]) mCanc[i]++;
         end
         if (acc && isNonseq) begin
            mLeft[i] = (burstBeats(HBURSTS) > 0) ? burstBeats(HBURSTS) - 1 : 0;
         end else if (acc && isSeq && mLeft[i] > 0) begin
            mLeft[i]--;
         end
      end
   endtask

   task automatic applyStimulus(input logic [1:0] trans, input logic [2:0] burst,
                                input logic readyS, input logic readyM, input logic respM);
      HTRANSS = trans;
      HBURSTS = burst;
      HREADYS = readyS;
      HREADYM = readyM;
      HRESPM = respM;
   endtask

   // Called just after a falling edge with inputs applied; ends after the next falling edge.
   task automatic stepCycle();
      #1;
      checkAll();
      modelStep();
      @(posedge HCLK);
      @(negedge HCLK);
   endtask

   task automatic idleCycles(input int n);
      for (int k = 0; k < n; k++) begin
         applyStimulus(2'b00, 3'd0, 1'b1, 1'b1, 1'b0);
         stepCycle();
      end
   endtask

   task automatic clearCounters();
      CNTCLR = 1'b1;
      applyStimulus(2'b00, 3'd0, 1'b1, 1'b1, 1'b0);
      stepCycle();
      CNTCLR = 1'b0;
   endtask

   initial begin
      HRESETn = 1'b0;
      HCLKEN = 1'b1;
      HSELS = 1'b1;
      CNTCLR = 1'b0;
      applyStimulus(2'b00, 3'd0, 1'b1, 1'b1, 1'b0);
      modelReset();
      repeat (2) @(negedge HCLK);
      #1;
      checkAll();
      HRESETn = 1'b1;
      @(negedge HCLK);

      // INCR4 with error on beat 2: beats 3 and 4 cancelled.
      clearCounters();
      applyStimulus(2'b10, 3'd3, 1, 1, 0); stepCycle();
      applyStimulus(2'b11, 3'd3, 1, 1, 0); stepCycle();
      applyStimulus(2'b11, 3'd3, 0, 0, 1); stepCycle();
      applyStimulus(2'b11, 3'd3, 1, 1, 1); stepCycle();
      applyStimulus(2'b11, 3'd3, 0, 1, 0);
      #1 checkOutput("incr4_err1_ready", 32'(readyOut[0]), 0);
      stepCycle();
      applyStimulus(2'b11, 3'd3, 1, 1, 0); stepCycle();
      applyStimulus(2'b00, 3'd3, 0, 1, 0); stepCycle();
      applyStimulus(2'b00, 3'd3, 1, 1, 0);
      #1 checkOutput("incr4_htransm_idle", 32'(transM[0]), 0);
      stepCycle();
      applyStimulus(2'b00, 3'd0, 1, 1, 0);
      #1;
      checkOutput("incr4_canccnt", 32'(cancCnt0), 2);
      checkOutput("incr4_errcnt", 32'(errCnt0), 1);
      checkOutput("incr4_cancelling_off", 32'(cancellingOut[0]), 0);
      stepCycle();
      idleCycles(2);

      // INCR with error on beat 1: dut1 (no INCR cancel) keeps passing beats through.
      clearCounters();
      applyStimulus(2'b10, 3'd1, 1, 1, 0); stepCycle();
      applyStimulus(2'b11, 3'd1, 0, 0, 1); stepCycle();
      applyStimulus(2'b11, 3'd1, 1, 1, 1); stepCycle();
      applyStimulus(2'b11, 3'd1, 1, 1, 0);
      #1 checkOutput("incr_pass_htransm", 32'(transM[1]), 3);
      stepCycle();
      applyStimulus(2'b11, 3'd1, 1, 1, 0); stepCycle();
      applyStimulus(2'b00, 3'd1, 1, 1, 0); stepCycle();
      applyStimulus(2'b00, 3'd0, 1, 1, 0);
      #1;
      checkOutput("incr_pass_canccnt", 32'(cancCnt1), 0);
      checkOutput("incr_pass_errcnt", 32'(errCnt1), 1);
      checkOutput("incr_pass_cancelling", 32'(cancellingOut[1]), 0);
      stepCycle();
      idleCycles(2);

      // WRAP8 with error on beat 3 and a BUSY in the cancelled tail.
      clearCounters();
      applyStimulus(2'b10, 3'd4, 1, 1, 0); stepCycle();
      applyStimulus(2'b11, 3'd4, 1, 1, 0); stepCycle();
      applyStimulus(2'b11, 3'd4, 1, 1, 0); stepCycle();
      applyStimulus(2'b11, 3'd4, 0, 0, 1); stepCycle();
      applyStimulus(2'b11, 3'd4, 1, 1, 1); stepCycle();
      applyStimulus(2'b11, 3'd4, 0, 1, 0); stepCycle();
      applyStimulus(2'b11, 3'd4, 1, 1, 0); stepCycle();
      applyStimulus(2'b01, 3'd4, 0, 1, 0); stepCycle();
      applyStimulus(2'b01, 3'd4, 1, 1, 0); stepCycle();
      applyStimulus(2'b11, 3'd4, 1, 1, 0);
      #1;
      checkOutput("wrap8_busy_ready", 32'(readyOut[0]), 1);
      checkOutput("wrap8_busy_okay", 32'(respOut[0]), 0);
      stepCycle();
      applyStimulus(2'b11, 3'd4, 0, 1, 0); stepCycle();
      applyStimulus(2'b11, 3'd4, 1, 1, 0); stepCycle();
      applyStimulus(2'b11, 3'd4, 0, 1, 0); stepCycle();
      applyStimulus(2'b11, 3'd4, 1, 1, 0); stepCycle();
      applyStimulus(2'b00, 3'd4, 0, 1, 0); stepCycle();
      applyStimulus(2'b01, 3'd4, 1, 1, 0); stepCycle();
      applyStimulus(2'b00, 3'd4, 1, 1, 0);
      #1;
      checkOutput("wrap8_exit_at_zero", 32'(cancellingOut[0]), 0);
      checkOutput("wrap8_no_track_stays", 32'(cancellingOut[1]), 1);
      checkOutput("wrap8_canccnt", 32'(cancCnt0), 5);
      stepCycle();
      idleCycles(2);

      // Final beat errors, next burst's NONSEQ must reach AHB2 with the last error cycle.
      clearCounters();
      applyStimulus(2'b10, 3'd3, 1, 1, 0); stepCycle();
      applyStimulus(2'b11, 3'd3, 1, 1, 0); stepCycle();
      applyStimulus(2'b11, 3'd3, 1, 1, 0); stepCycle();
      applyStimulus(2'b11, 3'd3, 0, 0, 1); stepCycle();
      applyStimulus(2'b11, 3'd3, 1, 1, 1); stepCycle();
      applyStimulus(2'b10, 3'd0, 0, 1, 0); stepCycle();
      applyStimulus(2'b10, 3'd0, 1, 1, 0);
      #1;
      checkOutput("nonseq_fwd_htransm", 32'(transM[0]), 2);
      checkOutput("nonseq_fwd_ready", 32'(readyOut[0]), 1);
      checkOutput("nonseq_fwd_resp", 32'(respOut[0]), 1);
      stepCycle();
      applyStimulus(2'b00, 3'd0, 1, 1, 0);
      #1 checkOutput("nonseq_fwd_pass", 32'(cancellingOut[0]), 0);
      stepCycle();
      idleCycles(1);

      // Error counter saturation, then clear racing an increment.
      clearCounters();
      for (int k = 0; k < 260; k++) begin
         applyStimulus(2'b00, 3'd0, 1, 0, 1);
         stepCycle();
      end
      applyStimulus(2'b00, 3'd0, 1, 0, 1);
      #1;
      checkOutput("errcnt_sat8", 32'(errCnt0), 255);
      checkOutput("errcnt_sat4", 32'(errCnt1), 15);
      CNTCLR = 1'b1;
      stepCycle();
      CNTCLR = 1'b0;
      applyStimulus(2'b00, 3'd0, 1, 1, 0);
      #1 checkOutput("errcnt_clr_priority", 32'(errCnt0), 0);
      stepCycle();

      // Clock enable low: counters hold, pass-through stays live.
      HCLKEN = 1'b0;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(2'b11, 3'd3, 0, 0, 1);
         stepCycle();
      end
      HCLKEN = 1'b1;
      applyStimulus(2'b00, 3'd0, 1, 1, 0);
      #1;
      checkOutput("clken_hold_errcnt", 32'(errCnt0), 0);
      checkOutput("clken_hold_cancel", 32'(cancellingOut[0]), 0);
      stepCycle();

      // Asynchronous reset while the generator is in its stalled error cycle.
      clearCounters();
      applyStimulus(2'b10, 3'd3, 1, 1, 0); stepCycle();
      applyStimulus(2'b11, 3'd3, 1, 1, 0); stepCycle();
      applyStimulus(2'b11, 3'd3, 0, 0, 1); stepCycle();
      applyStimulus(2'b11, 3'd3, 1, 1, 1); stepCycle();
      applyStimulus(2'b11, 3'd3, 0, 1, 0);
      #1 checkOutput("rst_pre_err1", 32'(readyOut[0]), 0);
      HRESETn = 1'b0;
      #1;
      checkOutput("rst_ready_pass", 32'(readyOut[0]), 1);
      checkOutput("rst_trans_pass", 32'(transM[0]), 3);
      checkOutput("rst_errcnt", 32'(errCnt0), 0);
      checkOutput("rst_canccnt", 32'(cancCnt0), 0);
      checkOutput("rst_cancelling", 32'(cancellingOut[0]), 0);
      modelReset();
      @(negedge HCLK);
      HRESETn = 1'b1;
      applyStimulus(2'b10, 3'd3, 1, 1, 0);
      #1 checkOutput("post_rst_nonseq", 32'(transM[0]), 2);
      stepCycle();
      idleCycles(2);

      // Randomized traffic checked against the model every cycle.
      for (int k = 0; k < 3000; k++) begin
         HCLKEN = ($urandom_range(0, 99) < 90);
         HSELS = ($urandom_range(0, 99) < 90);
         CNTCLR = ($urandom_range(0, 99) < 2);
         applyStimulus(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 75),
                       ($urandom_range(0, 99) < 15));
         stepCycle();
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
